load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 52 +++++
 rtl/load_extend.sv | 32 +++
 rtl/load_store_unit.sv | 155 +++++++++++++++
 tb/tb_load_store_unit.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store definitions: FSM states, funct3 encodings, request decode helpers.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    // Is this funct3 a legal access size/sign for the request direction and data width?
    function automatic logic f3_legal(input logic is_write, input logic is_64, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (is_write) begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = is_64;
                default:          ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = is_64;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Natural alignment check; size is funct3[1:0] (log2 of access bytes).
    function automatic logic addr_aligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic ok;
        case (size)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (addr_lo[0] == 1'b0);
            2'b10:   ok = (addr_lo[1:0] == 2'b00);
            default: ok = (addr_lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed lane out of a RAM word and sign/zero-extends it per funct3.
module load_extend
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    localparam int unsigned OFF_W = $clog2(WIDTH / 8)
) (
    input  logic [WIDTH-1:0] lane_data,
    input  logic [OFF_W-1:0] offset,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] rsp_rdata
);

    logic [WIDTH-1:0] shifted;

    // Shift the addressed byte lane down to bit 0, then extend to full width.
    always_comb begin
        shifted   = lane_data >> {offset, 3'b000};
        rsp_rdata = '0;
        case (funct3)
            F3_B:    rsp_rdata = WIDTH'($signed(shifted[7:0]));
            F3_H:    rsp_rdata = WIDTH'($signed(shifted[15:0]));
            F3_W:    rsp_rdata = WIDTH'($signed(shifted[31:0]));
            F3_D:    rsp_rdata = shifted;
            F3_BU:   rsp_rdata = WIDTH'(shifted[7:0]);
            F3_HU:   rsp_rdata = WIDTH'(shifted[15:0]);
            F3_WU:   rsp_rdata = WIDTH'(shifted[31:0]);
            default: rsp_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Core-to-RAM load/store unit: decodes, aligns and issues one access at a time with ack timeout.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               req_valid,
    input  logic               req_write,
    input  logic [2:0]         req_funct3,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               stall,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               err_align,
    output logic               err_timeout,
    output logic               ram_req,
    input  logic               ram_ack,
    output logic [WIDTH-1:0]   ram_address,
    output logic [WIDTH-1:0]   ram_w_data,
    output logic [WIDTH/8-1:0] ram_byte_en,
    output logic               Read_Write_ram_en,
    input  logic [WIDTH-1:0]   ram_r_data
);

    localparam int unsigned NB    = WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam bit          IS_64 = (WIDTH == 64);

    lsu_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;

    logic             req_ok_c;
    logic [NB-1:0]    be_base_c;
    logic [NB-1:0]    be_c;
    logic [WIDTH-1:0] wdata_rep_c;
    logic             cnt_last_c;
    logic [WIDTH-1:0] load_ext_c;

    // Request decode: legality, byte strobes at the addressed lane, lane-replicated store data.
    always_comb begin
        req_ok_c    = f3_legal(req_write, IS_64, req_funct3) &&
                      addr_aligned(req_funct3[1:0], req_addr[2:0]);
        be_base_c   = '1;
        wdata_rep_c = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_base_c   = NB'(1);
                wdata_rep_c = {NB{req_wdata[7:0]}};
            end
            2'b01: begin
                be_base_c   = NB'(2'b11);
                wdata_rep_c = {(NB/2){req_wdata[15:0]}};
            end
            2'b10: begin
                be_base_c   = NB'(4'hF);
                wdata_rep_c = {(WIDTH/32){req_wdata[31:0]}};
            end
            default: begin
                be_base_c   = '1;
                wdata_rep_c = req_wdata;
            end
        endcase
        be_c       = be_base_c << req_addr[OFF_W-1:0];
        cnt_last_c = (wait_cnt == CNT_W'(MAX_WAIT - 1));
    end

    // Core must hold while a request is being accepted or the RAM access is outstanding.
    always_comb begin
        stall = RESET && (((state == ST_IDLE) && req_valid) || (state == ST_ACCESS));
    end

    load_extend #(
        .WIDTH (WIDTH)
    ) u_load_extend (
        .lane_data (ram_r_data),
        .offset    (off_q),
        .funct3    (f3_q),
        .rsp_rdata (load_ext_c)
    );

    // Access FSM with registered RAM-side and response-side outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            f3_q              <= '0;
            off_q             <= '0;
            ram_req           <= 1'b0;
            ram_address       <= '0;
            ram_w_data        <= '0;
            ram_byte_en       <= '0;
            Read_Write_ram_en <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_rdata         <= '0;
            err_align         <= 1'b0;
            err_timeout       <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_ok_c) begin
                            state             <= ST_ACCESS;
                            wait_cnt          <= '0;
                            f3_q              <= req_funct3;
                            off_q             <= req_addr[OFF_W-1:0];
                            ram_req           <= 1'b1;
                            ram_address       <= {req_addr[WIDTH-1:OFF_W], OFF_W'(0)};
                            ram_w_data        <= wdata_rep_c;
                            ram_byte_en       <= be_c;
                            Read_Write_ram_en <= req_write;
                        end else begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            err_align <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (ram_ack) begin
                        state     <= ST_RESP;
                        ram_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= Read_Write_ram_en ? '0 : load_ext_c;
                    end else if (cnt_last_c) begin
                        state       <= ST_RESP;
                        ram_req     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (WIDTH=32) with a response scoreboard queue.
module tb_load_store_unit;

    localparam int unsigned W = 32;

    logic           CLOCK;
    logic           RESET;
    logic           req_valid;
    logic           req_write;
    logic [2:0]     req_funct3;
    logic [W-1:0]   req_addr;
    logic [W-1:0]   req_wdata;
    logic           stall;
    logic           rsp_valid;
    logic [W-1:0]   rsp_rdata;
    logic           err_align;
    logic           err_timeout;
    logic           ram_req;
    logic           ram_ack;
    logic [W-1:0]   ram_address;
    logic [W-1:0]   ram_w_data;
    logic [W/8-1:0] ram_byte_en;
    logic           Read_Write_ram_en;
    logic [W-1:0]   ram_r_data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        ea;
        logic        et;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   rsp_exp;
    int   rsp_cnt = 0;

    load_store_unit #(
        .WIDTH    (W),
        .MAX_WAIT (15)
    ) dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .req_valid         (req_valid),
        .req_write         (req_write),
        .req_funct3        (req_funct3),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .stall             (stall),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .err_align         (err_align),
        .err_timeout       (err_timeout),
        .ram_req           (ram_req),
        .ram_ack           (ram_ack),
        .ram_address       (ram_address),
        .ram_w_data        (ram_w_data),
        .ram_byte_en       (ram_byte_en),
        .Read_Write_ram_en (Read_Write_ram_en),
        .ram_r_data        (ram_r_data)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Count every response pulse so stray pulses are caught at the end.
    always @(negedge CLOCK) begin
        if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Present a request for one cycle; returns stall as seen in the acceptance cycle.
    task automatic send_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output logic acc_stall);
        @(posedge CLOCK); #1;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        @(negedge CLOCK);
        acc_stall = stall;
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
    endtask

    // Raise ram_ack in the k-th ACCESS cycle (call while in ACCESS cycle 1).
    task automatic ack_in(input int k, input logic [31:0] d);
        repeat (k - 1) begin
            @(posedge CLOCK); #1;
        end
        ram_ack    = 1'b1;
        ram_r_data = d;
        @(posedge CLOCK); #1;
        ram_ack    = 1'b0;
        ram_r_data = $urandom;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [31:0] v;
        int n;
        v = '0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(int'(off) + i) +: 8];
        if (!f3[2] && v[8*n - 1]) begin
            for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic test_reset();
        RESET = 1'b0; req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h100;
        ram_ack = 1'b1; ram_r_data = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        total++;
        if ({stall, rsp_valid, rsp_rdata, err_align, err_timeout, ram_req, ram_address,
             ram_w_data, ram_byte_en, Read_Write_ram_en} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got stall=%b rsp_valid=%b ram_req=%b ram_address=%h ram_byte_en=%b, want all zero",
                     stall, rsp_valid, ram_req, ram_address, ram_byte_en);
        end
        req_valid = 1'b0; ram_ack = 1'b0;
        #1 RESET = 1'b1;
        @(negedge CLOCK);
        total++;
        if ({stall, ram_req, rsp_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle: got stall/ram_req/rsp_valid=%b, want 000", {stall, ram_req, rsp_valid});
        end
    endtask

    task automatic test_lw();
        logic s;
        exp_t e;
        exp_q.push_back(exp_t'({32'hDEAD_BEEF, 1'b0, 1'b0})); rsp_exp++;
        send_req(1'b0, 3'b010, 32'h104, 32'h0, s);
        total++;
        if (s !== 1'b1) begin bad++; $display("FAIL lw_accept_stall: got %b want 1", s); end
        @(negedge CLOCK);
        total++;
        if ({ram_req, stall, Read_Write_ram_en} !== 3'b110) begin
            bad++; $display("FAIL lw_access_ctrl: got %b want 110", {ram_req, stall, Read_Write_ram_en});
        end
        total++;
        if (ram_address !== 32'h104) begin bad++; $display("FAIL lw_addr: got %h want 00000104", ram_address); end
        total++;
        if (ram_byte_en !== 4'b1111) begin bad++; $display("FAIL lw_be: got %b want 1111", ram_byte_en); end
        ack_in(2, 32'hDEAD_BEEF);
        @(negedge CLOCK);
        e = exp_q.pop_front();
        total++;
        if ({rsp_valid, stall, rsp_rdata, err_align, err_timeout} !== {1'b1, 1'b0, e}) begin
            bad++;
            $display("FAIL lw_rsp: got valid=%b stall=%b rdata=%h ea=%b et=%b want 1 0 %h %b %b",
                     rsp_valid, stall, rsp_rdata, err_align, err_timeout, e.rdata, e.ea, e.et);
        end
        @(negedge CLOCK);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lw_rsp_pulse: got rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_lb();
        logic s;
        exp_t e;
        logic [2:0]  f3s  [2] = '{3'b000, 3'b100};
        logic [31:0] want [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(exp_t'({want[i], 1'b0, 1'b0})); rsp_exp++;
            send_req(1'b0, f3s[i], 32'h203, 32'h0, s);
            @(negedge CLOCK);
            total++;
            if ({ram_address, ram_byte_en} !== {32'h200, 4'b1000}) begin
                bad++; $display("FAIL lb_be[%0d]: got addr=%h be=%b want 00000200 1000", i, ram_address, ram_byte_en);
            end
            ack_in(1, 32'h8011_2233);
            @(negedge CLOCK);
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, rsp_rdata, err_align, err_timeout} !== {1'b1, e}) begin
                bad++;
                $display("FAIL lb_rsp[%0d]: got valid=%b rdata=%h ea=%b et=%b want 1 %h 0 0",
                         i, rsp_valid, rsp_rdata, err_align, err_timeout, e.rdata);
            end
        end
    endtask

    task automatic test_store();
        logic s;
        exp_t e;
        logic [2:0]  f3s  [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] adr  [3] = '{32'h302, 32'h201, 32'h304};
        logic [31:0] wd   [3] = '{32'h0000_ABCD, 32'h1234_565A, 32'h1122_3344};
        logic [31:0] wrep [3] = '{32'hABCD_ABCD, 32'h5A5A_5A5A, 32'h1122_3344};
        logic [3:0]  wbe  [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exp_t'({32'h0, 1'b0, 1'b0})); rsp_exp++;
            send_req(1'b1, f3s[i], adr[i], wd[i], s);
            @(negedge CLOCK);
            total++;
            if ({ram_w_data, ram_byte_en, Read_Write_ram_en, ram_req} !== {wrep[i], wbe[i], 1'b1, 1'b1}) begin
                bad++;
                $display("FAIL store_ram[%0d]: got wdata=%h be=%b rw=%b req=%b want %h %b 1 1",
                         i, ram_w_data, ram_byte_en, Read_Write_ram_en, ram_req, wrep[i], wbe[i]);
            end
            ack_in(1, 32'hCAFE_F00D);
            @(negedge CLOCK);
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, rsp_rdata, err_align, err_timeout} !== {1'b1, e}) begin
                bad++;
                $display("FAIL store_rsp[%0d]: got valid=%b rdata=%h ea=%b et=%b want 1 0 0 0",
                         i, rsp_valid, rsp_rdata, err_align, err_timeout);
            end
        end
    endtask

    task automatic test_misaligned();
        logic s;
        exp_t e;
        logic        ws  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f3s [7] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b011, 3'b100, 3'b111};
        logic [31:0] adr [7] = '{32'h101, 32'h203, 32'h102, 32'h100, 32'h100, 32'h100, 32'h100};
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(exp_t'({32'h0, 1'b1, 1'b0})); rsp_exp++;
            send_req(ws[i], f3s[i], adr[i], 32'hFFFF_FFFF, s);
            total++;
            if (s !== 1'b1) begin bad++; $display("FAIL misal_stall[%0d]: got %b want 1", i, s); end
            @(negedge CLOCK);
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, stall, ram_req, rsp_rdata, err_align, err_timeout} !== {1'b1, 1'b0, 1'b0, e}) begin
                bad++;
                $display("FAIL misal_rsp[%0d]: got valid=%b stall=%b req=%b rdata=%h ea=%b et=%b want 1 0 0 0 1 0",
                         i, rsp_valid, stall, ram_req, rsp_rdata, err_align, err_timeout);
            end
            @(negedge CLOCK);
            total++;
            if ({ram_req, stall, err_align} !== 3'b000) begin
                bad++; $display("FAIL misal_after[%0d]: got req/stall/ea=%b want 000", i, {ram_req, stall, err_align});
            end
        end
    endtask

    task automatic test_timeout();
        logic s;
        logic seen;
        int   n;
        exp_t e;
        exp_q.push_back(exp_t'({32'h0, 1'b0, 1'b1})); rsp_exp++;
        send_req(1'b0, 3'b010, 32'h400, 32'h0, s);
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLOCK);
            if (ram_req === 1'b1) n++;
            if (rsp_valid === 1'b1) seen = 1'b1;
            else @(posedge CLOCK);
        end
        total++;
        if (seen !== 1'b1 || n != 15) begin
            bad++; $display("FAIL timeout_cycles: got seen=%b access_cycles=%0d want 1 15", seen, n);
        end
        e = exp_q.pop_front();
        total++;
        if ({rsp_valid, rsp_rdata, err_align, err_timeout} !== {1'b1, e}) begin
            bad++;
            $display("FAIL timeout_rsp: got valid=%b rdata=%h ea=%b et=%b want 1 0 0 1",
                     rsp_valid, rsp_rdata, err_align, err_timeout);
        end
    endtask

    task automatic test_ack_at_limit();
        logic s;
        exp_t e;
        exp_q.push_back(exp_t'({32'h1357_9BDF, 1'b0, 1'b0})); rsp_exp++;
        send_req(1'b0, 3'b010, 32'h408, 32'h0, s);
        ack_in(15, 32'h1357_9BDF);
        @(negedge CLOCK);
        e = exp_q.pop_front();
        total++;
        if ({rsp_valid, rsp_rdata, err_align, err_timeout} !== {1'b1, e}) begin
            bad++;
            $display("FAIL ack_limit_rsp: got valid=%b rdata=%h ea=%b et=%b want 1 %h 0 0",
                     rsp_valid, rsp_rdata, err_align, err_timeout, e.rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic s;
        send_req(1'b0, 3'b010, 32'h500, 32'h0, s);
        @(posedge CLOCK); #1;
        req_valid = 1'b1; req_addr = 32'h600;
        #1 RESET = 1'b0;
        #1;
        total++;
        if ({stall, rsp_valid, rsp_rdata, err_align, err_timeout, ram_req, ram_address,
             ram_w_data, ram_byte_en, Read_Write_ram_en} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got stall=%b ram_req=%b ram_address=%h ram_byte_en=%b, want all zero",
                     stall, ram_req, ram_address, ram_byte_en);
        end
        @(posedge CLOCK); #1;
        req_valid = 1'b0;
        RESET = 1'b1;
        ram_ack = 1'b1; ram_r_data = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            total++;
            if ({rsp_valid, ram_req, err_align, err_timeout, stall} !== 5'b0) begin
                bad++;
                $display("FAIL reset_mid_late_ack[%0d]: got valid/req/ea/et/stall=%b want 00000",
                         i, {rsp_valid, ram_req, err_align, err_timeout, stall});
            end
        end
        ram_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        s;
        exp_t        e;
        logic [2:0]  lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          n;
        for (int t = 0; t < 10; t++) begin
            f3 = lf3[$urandom_range(0, 4)];
            case (f3[1:0])
                2'b00:   off = 2'($urandom_range(0, 3));
                2'b01:   off = {1'($urandom_range(0, 1)), 1'b0};
                default: off = 2'b00;
            endcase
            a = 32'h2000 + 32'($urandom_range(0, 255)) * 4 + 32'(off);
            d = $urandom;
            n = 1 << f3[1:0];
            be = '0;
            for (int i = 0; i < n; i++) be[int'(off) + i] = 1'b1;
            exp_q.push_back(exp_t'({model_load(f3, off, d), 1'b0, 1'b0})); rsp_exp++;
            send_req(1'b0, f3, a, 32'h0, s);
            @(negedge CLOCK);
            total++;
            if ({ram_address, ram_byte_en} !== {a & 32'hFFFF_FFFC, be}) begin
                bad++;
                $display("FAIL b2b_ram[%0d]: got addr=%h be=%b want %h %b", t, ram_address, ram_byte_en,
                         a & 32'hFFFF_FFFC, be);
            end
            ack_in($urandom_range(1, 3), d);
            @(negedge CLOCK);
            e = exp_q.pop_front();
            total++;
            if ({rsp_valid, rsp_rdata, err_align, err_timeout} !== {1'b1, e}) begin
                bad++;
                $display("FAIL b2b_rsp[%0d]: f3=%b addr=%h data=%h got valid=%b rdata=%h ea=%b et=%b want 1 %h 0 0",
                         t, f3, a, d, rsp_valid, rsp_rdata, err_align, err_timeout, e.rdata);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; rsp_exp = 0;
        RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; ram_ack = 1'b0; ram_r_data = '0;
        test_reset();
        test_lw();
        test_lb();
        test_store();
        test_misaligned();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        test_back_to_back();
        @(negedge CLOCK);
        total++;
        if (rsp_cnt != rsp_exp) begin
            bad++; $display("FAIL rsp_count: got %0d response pulses want %0d", rsp_cnt, rsp_exp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
